frame_ram: RTL and testbench

- Parametrised successor to the 4x8 scratch RAM: a simple-dual-port pixel-row store with independent write and read ports.
- Adds per-bit write masking, registered read with valid flag, selectable read-during-write mode, and a hardware clear sequencer that sweeps every address.
- Sits between the pixel-drawing logic (write side) and the display scan-out (read side); one row of pixels per word.

---
 rtl/frame_ram_pkg.sv | 14 +
 rtl/frame_ram_clear_seq.sv | 72 +++++++
 rtl/frame_ram.sv | 81 ++++++++
 tb/tb_frame_ram.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_ram_pkg.sv
// Shared types for the pixel-row frame RAM: clear-sequencer states and
// read-during-write mode selectors.
package frame_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  localparam int READ_FIRST    = 0;
  localparam int WRITE_THROUGH = 1;

endpackage

// File: rtl/frame_ram_clear_seq.sv
// Clear sequencer: sweeps every address with a latched fill value, one word per cycle.
// Sweep lasts 2**ADDR_W cycles in CLEAR, followed by a single DONE cycle.
module frame_ram_clear_seq
  import frame_ram_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 64,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_val,
  output logic              idle,
  output logic              busy,
  output logic              clear_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_data
);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] fill;
  logic              auto_pend;
  logic              start;

  // auto_pend arms the post-reset sweep; it is consumed by the first start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      auto_pend <= (CLEAR_ON_RESET != 0);
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt       <= '0;
        auto_pend <= 1'b0;
      end else if (state == ST_CLEAR) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) fill <= auto_pend ? '0 : clear_val;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (auto_pend || clear_req) begin
          start     = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: if (cnt == {ADDR_W{1'b1}}) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign idle       = (state == ST_IDLE);
  assign busy       = (state == ST_CLEAR);
  assign clear_done = (state == ST_DONE);
  assign clr_we     = (state == ST_CLEAR);
  assign clr_addr   = cnt;
  assign clr_data   = fill;

endmodule

// File: rtl/frame_ram.sv
// Simple-dual-port pixel-row store with per-bit write mask, registered read (latency 1)
// and a hardware clear sweep that locks out user access while it runs.
module frame_ram
  import frame_ram_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 64,
  parameter int RDW_MODE       = READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_val,
  output logic              busy,
  output logic              clear_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic              user_wr;
  logic              user_rd;
  logic [DATA_W-1:0] merged;

  frame_ram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_val  (clear_val),
    .idle       (idle),
    .busy       (busy),
    .clear_done (clear_done),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .clr_data   (clr_data)
  );

  assign user_wr = wr_en & idle;
  assign user_rd = rd_en & idle;

  always_comb merged = (wr_data & wr_mask) | (mem[wr_addr] & ~wr_mask);

  // Array has no reset; the sweep and user writes never coincide.
  always_ff @(posedge clk) begin
    if (clr_we)       mem[clr_addr] <= clr_data;
    else if (user_wr) mem[wr_addr]  <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= user_rd;
      if (user_rd) begin
        if ((RDW_MODE == WRITE_THROUGH) && user_wr && (wr_addr == rd_addr))
          rd_data <= merged;
        else
          rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_frame_ram.sv
// Drives a read-first/auto-clear instance and a write-through/no-auto-clear instance
// side by side and compares both against an array-based reference model.
module tb_frame_ram;

  logic        clk = 1'b0;
  logic        reset0, reset1;
  logic        wr_en, rd_en, clear_req;
  logic [5:0]  wr_addr, rd_addr;
  logic [63:0] wr_data, wr_mask, clear_val;
  logic [63:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, busy0, busy1, clear_done0, clear_done1;

  always #5 clk = ~clk;

  frame_ram #(.ADDR_W(6), .DATA_W(64), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset(reset0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .clear_req(clear_req), .clear_val(clear_val),
    .busy(busy0), .clear_done(clear_done0)
  );

  frame_ram #(.ADDR_W(6), .DATA_W(64), .RDW_MODE(1), .CLEAR_ON_RESET(0)) dut1 (
    .clk(clk), .reset(reset1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .clear_req(clear_req), .clear_val(clear_val),
    .busy(busy1), .clear_done(clear_done1)
  );

  // Reference contents and expected held read data per instance
  logic [63:0] m0 [64];
  logic [63:0] m1 [64];
  logic [63:0] exp0, exp1;
  bit          m1_ok;
  int          n_chk, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic we, input logic [5:0] wa, input logic [63:0] wd,
                        input logic [63:0] wm, input logic re, input logic [5:0] ra,
                        input string tag);
    logic [63:0] mg0, mg1;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    rd_en = re; rd_addr = ra;
    mg0 = (wd & wm) | (m0[wa] & ~wm);
    mg1 = (wd & wm) | (m1[wa] & ~wm);
    if (re) begin
      exp0 = m0[ra];
      exp1 = (we && wa == ra) ? mg1 : m1[ra];
    end
    if (we) begin
      m0[wa] = mg0;
      m1[wa] = mg1;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check({tag, "_vld0"}, 64'(rd_valid0), 64'(re));
    check({tag, "_vld1"}, 64'(rd_valid1), 64'(re));
    check({tag, "_dat0"}, rd_data0, exp0);
    if (m1_ok) check({tag, "_dat1"}, rd_data1, exp1);
  endtask

  // Fixed observation window long enough for a full sweep plus its DONE cycle
  task automatic watch(output int b0, output int b1, output int d0, output int d1);
    b0 = 0; b1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk); #1;
      b0 += int'(busy0); b1 += int'(busy1);
      d0 += int'(clear_done0); d1 += int'(clear_done1);
    end
  endtask

  task automatic run_sweep(input logic [63:0] val, input bit touch, input bit co_write,
                           input int abort_at, input string tag);
    int b0, b1, d0, d1, rv;
    logic [63:0] mg1;
    @(negedge clk);
    clear_val = val; clear_req = 1'b1;
    if (co_write) begin
      wr_en = 1'b1; wr_addr = 6'd7; wr_data = 64'h55; wr_mask = '1;
      rd_en = 1'b1; rd_addr = 6'd7;
    end
    @(posedge clk); #1;
    clear_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_val = ~val;
    if (co_write) begin
      mg1 = 64'h55;
      check({tag, "_co_vld0"}, 64'(rd_valid0), 64'd1);
      check({tag, "_co_vld1"}, 64'(rd_valid1), 64'd1);
      check({tag, "_co_dat0"}, rd_data0, m0[7]);
      check({tag, "_co_dat1"}, rd_data1, mg1);
      exp0 = m0[7]; exp1 = mg1;
      m0[7] = 64'h55; m1[7] = 64'h55;
    end
    b0 = int'(busy0); b1 = int'(busy1);
    d0 = int'(clear_done0); d1 = int'(clear_done1); rv = 0;
    for (int i = 0; i < 80; i++) begin
      if (abort_at != 0 && b0 == abort_at) break;
      @(negedge clk);
      if (touch && busy0) begin
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = {$urandom, $urandom}; wr_mask = '1;
        rd_en = 1'b1; rd_addr = 6'd3;
        clear_req = (b0 == 30);
      end
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
      b0 += int'(busy0); b1 += int'(busy1);
      d0 += int'(clear_done0); d1 += int'(clear_done1);
      rv += int'(rd_valid0) + int'(rd_valid1);
    end
    if (abort_at == 0) begin
      check({tag, "_busy0"}, 64'(b0), 64'd64);
      check({tag, "_busy1"}, 64'(b1), 64'd64);
      check({tag, "_done0"}, 64'(d0), 64'd1);
      check({tag, "_done1"}, 64'(d1), 64'd1);
      check({tag, "_rvld"}, 64'(rv), 64'd0);
      check({tag, "_hold0"}, rd_data0, exp0);
      if (m1_ok) check({tag, "_hold1"}, rd_data1, exp1);
      for (int a = 0; a < 64; a++) begin
        m0[a] = val; m1[a] = val;
      end
      m1_ok = 1'b1;
    end else begin
      @(negedge clk);
      reset0 = 1'b1; reset1 = 1'b1;
      @(posedge clk); #1;
      check({tag, "_rst_busy0"}, 64'(busy0), 64'd0);
      check({tag, "_rst_busy1"}, 64'(busy1), 64'd0);
      check({tag, "_nodone0"}, 64'(d0), 64'd0);
      check({tag, "_nodone1"}, 64'(d1), 64'd0);
      check({tag, "_rst_dat0"}, rd_data0, 64'd0);
      check({tag, "_rst_dat1"}, rd_data1, 64'd0);
      @(negedge clk);
      reset0 = 1'b0; reset1 = 1'b0;
      for (int a = 0; a < abort_at; a++) m1[a] = val;
      for (int a = 0; a < 64; a++) m0[a] = '0;
      exp0 = '0; exp1 = '0;
      watch(b0, b1, d0, d1);
      check({tag, "_auto_busy0"}, 64'(b0), 64'd64);
      check({tag, "_auto_done0"}, 64'(d0), 64'd1);
      check({tag, "_auto_busy1"}, 64'(b1), 64'd0);
      check({tag, "_auto_done1"}, 64'(d1), 64'd0);
    end
  endtask

  initial begin
    int b0, b1, d0, d1;
    logic [63:0] fill, rd, rm;
    logic        we, re;
    logic [5:0]  wa, ra;
    n_chk = 0; n_err = 0; m1_ok = 1'b0;
    for (int a = 0; a < 64; a++) begin
      m0[a] = '0; m1[a] = '0;
    end
    exp0 = '0; exp1 = '0;
    reset0 = 1'b1; reset1 = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0; clear_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld0", 64'(rd_valid0), 64'd0);
    check("rst_vld1", 64'(rd_valid1), 64'd0);
    check("rst_dat0", rd_data0, 64'd0);
    check("rst_dat1", rd_data1, 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_done0", 64'(clear_done0), 64'd0);
    check("rst_done1", 64'(clear_done1), 64'd0);

    // Power-up sweep on the auto-clear instance only
    @(negedge clk);
    reset0 = 1'b0; reset1 = 1'b0;
    watch(b0, b1, d0, d1);
    check("por_busy0", 64'(b0), 64'd64);
    check("por_done0", 64'(d0), 64'd1);
    check("por_busy1", 64'(b1), 64'd0);
    check("por_done1", 64'(d1), 64'd0);
    access(1'b0, 6'd0, '0, '0, 1'b1, 6'h2A, "por_rd2a");
    check("por_rd2a_const", rd_data0, 64'd0);

    // Sweep with locked-out traffic on addr 3 and a redundant mid-sweep request
    run_sweep(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 0, "swA");
    access(1'b0, 6'd0, '0, '0, 1'b1, 6'd3, "swA_rd3");
    check("swA_rd3_const0", rd_data0, 64'hAAAA_AAAA_AAAA_AAAA);
    check("swA_rd3_const1", rd_data1, 64'hAAAA_AAAA_AAAA_AAAA);

    access(1'b1, 6'd5, '1, '1, 1'b0, 6'd0, "mw1");
    access(1'b1, 6'd5, '0, 64'h0000_0000_FFFF_0000, 1'b0, 6'd0, "mw2");
    access(1'b0, 6'd0, '0, '0, 1'b1, 6'd5, "mw_rd");
    check("mw_const0", rd_data0, 64'hFFFF_FFFF_0000_FFFF);
    check("mw_const1", rd_data1, 64'hFFFF_FFFF_0000_FFFF);
    access(1'b1, 6'd5, 64'h1234, '0, 1'b1, 6'd5, "mw_nomask");
    check("mw_nomask_const1", rd_data1, 64'hFFFF_FFFF_0000_FFFF);

    access(1'b1, 6'd9, 64'h11, '1, 1'b0, 6'd0, "rdw_pre");
    access(1'b1, 6'd9, 64'h22, '1, 1'b1, 6'd9, "rdw");
    check("rdw_const0", rd_data0, 64'h11);
    check("rdw_const1", rd_data1, 64'h22);

    // Random traffic concentrated on a few addresses to force collisions
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 6'($urandom_range(0, 15));
      ra = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom_range(0, 15));
      rd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rm = '0;
        1:       rm = '1;
        default: rm = {$urandom, $urandom};
      endcase
      access(we, wa, rd, rm, re, ra, "rnd");
    end

    fill = {$urandom, $urandom};
    run_sweep(fill, 1'b0, 1'b1, 0, "swW");
    access(1'b0, 6'd0, '0, '0, 1'b1, 6'd7, "swW_rd7");
    check("swW_rd7_fill", rd_data1, fill);

    access(1'b1, 6'd40, 64'h1234_5678_9ABC_DEF0, '1, 1'b0, 6'd0, "ab_pre40");
    access(1'b1, 6'd20, 64'h0BAD_F00D, '1, 1'b0, 6'd0, "ab_pre20");
    run_sweep(64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 1'b0, 20, "swR");
    for (int a = 0; a < 21; a++) access(1'b0, 6'd0, '0, '0, 1'b1, 6'(a), "swR_rd");
    access(1'b0, 6'd0, '0, '0, 1'b1, 6'd40, "swR_rd40");
    check("swR_rd40_const1", rd_data1, 64'h1234_5678_9ABC_DEF0);
    check("swR_rd40_const0", rd_data0, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
